ddr_burst_responder: RTL and testbench
======================================

// Module: ddr_burst_responder
// PURPOSE
//   Synthesizable DDR-port responder: the memory end of the ddr*_in / ddr*_out burst channels.
//   Accepts write bursts (addr+size, then data beats) into an on-chip RAM.
//   Serves read bursts (addr+size) by streaming stored beats back.
//   Terminates a traffic-generator port on FPGA for loopback bring-up without a real DDR controller.
// PARAMETERS
//   MEM_DEPTH  256  RAM depth in DDR_W-bit words; must be a power of 2
//   IDX_W      bw(MEM_DEPTH)-1  word-index width, derived (log2 MEM_DEPTH)
//   ADDR_LSB   log2(DDR_W/8)  byte-to-word shift; DDR_W, DDR_ADDR_W, BURST_W come from GLOBAL_PARAM
// PORTS
//   clk            in   1           clock; single clock domain
//   rst            in   1           synchronous, active-high reset
//   rd_addr        in   DDR_ADDR_W  read burst byte address (master's ddr_in_addr)
//   rd_size        in   BURST_W     read burst length in beats
//   rd_addr_valid  in   1           read request valid
//   rd_addr_ready  out  1           read request accepted
//   rd_data        out  DDR_W       read beat (master's ddr_in_data)
//   rd_valid       out  1           read beat valid
//   rd_ready       in   1           master accepts read beat
//   wr_addr        in   DDR_ADDR_W  write burst byte address (master's ddr_out_addr)
//   wr_size        in   BURST_W     write burst length in beats
//   wr_addr_valid  in   1           write request valid
//   wr_addr_ready  out  1           write request accepted
//   wr_data        in   DDR_W       write beat
//   wr_valid       in   1           write beat valid
//   wr_ready       out  1           responder accepts write beat
//   busy           out  1           either channel is mid-burst
// BEHAVIOUR
//   - Reset: every output 0 (incl. rd_data, both readies); FSMs to IDLE; counters 0. RAM contents kept.
//   - Handshakes: a transfer occurs on a cycle with valid&ready high; valid never waits on ready.
//   - Word index = addr[ADDR_LSB +: IDX_W]; upper address bits ignored.
//     Beat k of a burst uses (index+k) mod MEM_DEPTH (wraps at the top of the RAM).
//   - Write FSM, W_IDLE->W_DATA->W_IDLE:
//     . W_IDLE: wr_addr_ready=1. On handshake latch index and size.
//       size==0 stays in W_IDLE and accepts no beats.
//     . W_DATA: wr_ready=1. Each beat writes RAM; after beat size-1 -> W_IDLE.
//       wr_addr_ready=1 again the cycle after the last beat.
//   - Read FSM, R_IDLE->R_BURST->R_IDLE:
//     . R_IDLE: rd_addr_ready=1. On handshake latch index and size.
//       size==0 stays in R_IDLE and emits no beats.
//     . R_BURST: RAM read latency is 1; the read is followed by a 2-entry output skid buffer.
//       First rd_valid comes 2 cycles after the addr handshake.
//       With rd_ready held high: 1 beat/cycle, no bubbles.
//     . Backpressure: rd_data/rd_valid held stable until accepted.
//       Exactly size beats; after the last beat -> R_IDLE, rd_addr_ready=1 the next cycle.
//   - Channels independent and concurrent.
//     Same-cycle read and write of one index: read returns OLD data (read-first).
//   - busy = (W_DATA | R_BURST).
//   - rst mid-burst: burst abandoned next edge. No beat emitted or accepted in the reset cycle.
//     Partially written words remain in RAM.
// CONFIGURATION
//   DDR_RESP_STALL_EN defined:
//     16-bit LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1, advances every cycle, reset to seed).
//     When LFSR[0]=1: wr_ready forced 0 and no new rd beat is offered (held beat stays valid).
//     Purpose: exercises master backpressure handling.
//   Undefined: no LFSR logic; wr_ready/rd pipeline never self-stall.
// STRUCTURE
//   GLOBAL_PARAM package: add wr_state_t {W_IDLE,W_DATA} and rd_state_t {R_IDLE,R_BURST}.
//   Sub-module ddr_resp_ram: simple dual-port RAM, 1 write port, 1 read port,
//   1-cycle registered read, read-first, no reset.
// TESTING
//   1 Write wr_addr=0x0400<<ADDR_LSB, size=32, beats {ones,ones,zero,zero} quarters;
//     read same addr, size=32 -> 32 identical beats, back-to-back, first 2 cycles after handshake.
//   2 Read size=8 with rd_ready toggling 1,0,0,1... -> rd_data stable while stalled; 8 beats, in order, none lost.
//   3 Write index 250 size 8 (data=k) -> RAM words 250..255,0,1 = 0..7;
//     read index 250 size 8 returns 0..7.
//   4 Assert rst at beat 5 of a 32-beat write, then new read of index 0 size 4
//     -> all outputs 0 during rst; beats 0..4 written, rest old; read completes normally.
//   5 Same-cycle write of 0xFF.. to index 3 and read of index 3 (old 0x00..) -> read returns 0x00..;
//     a later read returns 0xFF.. .
//   6 rd_size=0 and wr_size=0 -> no rd_valid, wr_ready never 1; both addr_ready high the next cycle.

Source files
------------

// File: rtl/ddr_burst_responder_pkg.sv
// Shared widths and FSM state types for the DDR burst responder.
package ddr_burst_responder_pkg;

    localparam int DDR_W      = 64;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 8;
    localparam int ADDR_LSB   = $clog2(DDR_W / 8);

    typedef enum logic { W_IDLE, W_DATA }  wr_state_t;
    typedef enum logic { R_IDLE, R_BURST } rd_state_t;

endpackage

// File: rtl/ddr_burst_responder_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read, read-first, no reset.
module ddr_resp_ram #(
    parameter int DW = 64,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddr_burst_responder.sv
// Memory end of a DDR burst port pair: write bursts land in on-chip RAM, read bursts stream back.
// Optional DDR_RESP_STALL_EN adds LFSR-driven self-stalling to exercise master backpressure.
module ddr_burst_responder
    import ddr_burst_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DDR_ADDR_W-1:0] rd_addr,
    input  logic [BURST_W-1:0]    rd_size,
    input  logic                  rd_addr_valid,
    output logic                  rd_addr_ready,
    output logic [DDR_W-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic [DDR_ADDR_W-1:0] wr_addr,
    input  logic [BURST_W-1:0]    wr_size,
    input  logic                  wr_addr_valid,
    output logic                  wr_addr_ready,
    input  logic [DDR_W-1:0]      wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t word_idx(input logic [DDR_ADDR_W-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    logic stall, stall_nxt;

`ifdef DDR_RESP_STALL_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign stall     = lfsr_q[0];
    assign stall_nxt = lfsr_d[0];
`else
    assign stall     = 1'b0;
    assign stall_nxt = 1'b0;
`endif

    // Upper address bits are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{rd_addr, wr_addr};

    // ---------------- write channel ----------------
    wr_state_t          wr_state_q, wr_state_d;
    idx_t               wr_ptr_q, wr_ptr_d;
    logic [BURST_W-1:0] wr_left_q, wr_left_d;
    logic               wr_addr_ready_q, wr_addr_ready_d;
    logic               wr_ready_q, wr_ready_d;
    logic               ram_we;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_left_d  = wr_left_q;
        ram_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: if (wr_addr_valid && wr_addr_ready && wr_size != '0) begin
                wr_state_d = W_DATA;
                wr_ptr_d   = word_idx(wr_addr);
                wr_left_d  = wr_size;
            end
            W_DATA: if (wr_valid && wr_ready) begin
                ram_we    = 1'b1;
                wr_ptr_d  = wr_ptr_q + idx_t'(1);
                wr_left_d = wr_left_q - BURST_W'(1);
                if (wr_left_q == BURST_W'(1)) wr_state_d = W_IDLE;
            end
            default: ;
        endcase
        wr_addr_ready_d = (wr_state_d == W_IDLE);
        wr_ready_d      = (wr_state_d == W_DATA) && !stall_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q      <= W_IDLE;
            wr_ptr_q        <= '0;
            wr_left_q       <= '0;
            wr_addr_ready_q <= 1'b0;
            wr_ready_q      <= 1'b0;
        end else begin
            wr_state_q      <= wr_state_d;
            wr_ptr_q        <= wr_ptr_d;
            wr_left_q       <= wr_left_d;
            wr_addr_ready_q <= wr_addr_ready_d;
            wr_ready_q      <= wr_ready_d;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t          rd_state_q, rd_state_d;
    idx_t               rd_ptr_q, rd_ptr_d;
    logic [BURST_W-1:0] rd_issue_left_q, rd_issue_left_d;
    logic [BURST_W-1:0] rd_left_q, rd_left_d;
    logic               rd_addr_ready_q, rd_addr_ready_d;
    logic               ram_vld_q, ram_vld_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DDR_W-1:0]   rd_data_q, rd_data_d;
    logic               skid_vld_q, skid_vld_d;
    logic [DDR_W-1:0]   skid_data_q, skid_data_d;
    logic [DDR_W-1:0]   ram_rdata;
    idx_t               raddr;
    logic               issue, pop, room;
    logic [1:0]         occ;

    always_comb begin
        rd_state_d      = rd_state_q;
        rd_ptr_d        = rd_ptr_q;
        rd_issue_left_d = rd_issue_left_q;
        rd_left_d       = rd_left_q;
        issue           = 1'b0;
        raddr           = rd_ptr_q;
        pop             = rd_valid && rd_ready;
        // Beats in flight or buffered; a read may only be issued if the
        // two-entry output stage is guaranteed to have room when it lands.
        occ  = {1'b0, rd_valid_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
        room = (occ - {1'b0, pop}) < 2'd2;
        case (rd_state_q)
            R_IDLE: if (rd_addr_valid && rd_addr_ready && rd_size != '0) begin
                rd_state_d      = R_BURST;
                rd_left_d       = rd_size;
                raddr           = word_idx(rd_addr);
                issue           = !stall;
                rd_ptr_d        = raddr + idx_t'(issue);
                rd_issue_left_d = rd_size - BURST_W'(issue);
            end
            R_BURST: begin
                if (rd_issue_left_q != '0 && room && !stall) begin
                    issue           = 1'b1;
                    rd_ptr_d        = rd_ptr_q + idx_t'(1);
                    rd_issue_left_d = rd_issue_left_q - BURST_W'(1);
                end
                if (pop) begin
                    rd_left_d = rd_left_q - BURST_W'(1);
                    if (rd_left_q == BURST_W'(1)) rd_state_d = R_IDLE;
                end
            end
            default: ;
        endcase
        ram_vld_d       = issue;
        rd_addr_ready_d = (rd_state_d == R_IDLE);

        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if ((!rd_valid_q || pop) && !stall) begin
            if (skid_vld_q) begin
                rd_valid_d  = 1'b1;
                rd_data_d   = skid_data_q;
                skid_vld_d  = ram_vld_q;
                if (ram_vld_q) skid_data_d = ram_rdata;
            end else if (ram_vld_q) begin
                rd_valid_d = 1'b1;
                rd_data_d  = ram_rdata;
            end else begin
                rd_valid_d = 1'b0;
            end
        end else begin
            if (pop) rd_valid_d = 1'b0;
            if (ram_vld_q) begin
                skid_vld_d  = 1'b1;
                skid_data_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q      <= R_IDLE;
            rd_ptr_q        <= '0;
            rd_issue_left_q <= '0;
            rd_left_q       <= '0;
            rd_addr_ready_q <= 1'b0;
            ram_vld_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            skid_vld_q      <= 1'b0;
            skid_data_q     <= '0;
        end else begin
            rd_state_q      <= rd_state_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_issue_left_q <= rd_issue_left_d;
            rd_left_q       <= rd_left_d;
            rd_addr_ready_q <= rd_addr_ready_d;
            ram_vld_q       <= ram_vld_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
            skid_vld_q      <= skid_vld_d;
            skid_data_q     <= skid_data_d;
        end
    end

    logic busy_q, busy_d;
    always_comb busy_d = (wr_state_d == W_DATA) || (rd_state_d == R_BURST);

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end

    ddr_resp_ram #(.DW(DDR_W), .AW(IDX_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (issue),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // Outputs are forced low while rst is high so no beat moves in the reset cycle.
    assign wr_addr_ready = wr_addr_ready_q && !rst;
    assign wr_ready      = wr_ready_q && !rst;
    assign rd_addr_ready = rd_addr_ready_q && !rst;
    assign rd_valid      = rd_valid_q && !rst;
    assign rd_data       = rst ? '0 : rd_data_q;
    assign busy          = busy_q && !rst;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Self-checking bench for ddr_burst_responder: memory/queue model plus directed bursts.
module tb_ddr_burst_responder;
    import ddr_burst_responder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DDR_ADDR_W-1:0] rd_addr = '0;
    logic [BURST_W-1:0]    rd_size = '0;
    logic                  rd_addr_valid = 1'b0;
    logic                  rd_addr_ready;
    logic [DDR_W-1:0]      rd_data;
    logic                  rd_valid;
    logic                  rd_ready = 1'b1;
    logic [DDR_ADDR_W-1:0] wr_addr = '0;
    logic [BURST_W-1:0]    wr_size = '0;
    logic                  wr_addr_valid = 1'b0;
    logic                  wr_addr_ready;
    logic [DDR_W-1:0]      wr_data = '0;
    logic                  wr_valid = 1'b0;
    logic                  wr_ready;
    logic                  busy;

    ddr_burst_responder #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_size(rd_size), .rd_addr_valid(rd_addr_valid),
        .rd_addr_ready(rd_addr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .wr_addr(wr_addr), .wr_size(wr_size), .wr_addr_valid(wr_addr_valid),
        .wr_addr_ready(wr_addr_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [63:0] mem_m [256];
    logic [63:0] exp_q [$];
    logic [63:0] rd_log [$];
    int          w_idx = 0, w_left = 0, r_left = 0;
    int          cyc = 0, first_cyc = 0;
    bit          first_pending = 0, prev_pop = 0, prev_hold = 0, rst_prev = 0;
    logic [63:0] held = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_rd_data", rd_data, 64'd0);
            chk("rst_ctrl", {59'd0, rd_addr_ready, rd_valid, wr_addr_ready, wr_ready, busy}, 64'd0);
            w_left = 0; r_left = 0; exp_q.delete();
            first_pending = 0; prev_pop = 0; prev_hold = 0; rst_prev = 1;
        end else begin
            chk("rd_addr_ready", {63'd0, rd_addr_ready}, {63'd0, (r_left == 0) && !rst_prev});
            chk("wr_addr_ready", {63'd0, wr_addr_ready}, {63'd0, (w_left == 0) && !rst_prev});
            chk("wr_ready", {63'd0, wr_ready}, {63'd0, w_left > 0});
            chk("busy", {63'd0, busy}, {63'd0, (w_left > 0) || (r_left > 0)});
            if (exp_q.size() == 0)
                chk("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
            else if (first_pending) begin
                if (cyc < first_cyc) chk("rd_early", {63'd0, rd_valid}, 64'd0);
                else if (cyc == first_cyc) chk("rd_latency", {63'd0, rd_valid}, 64'd1);
            end else if (prev_pop)
                chk("rd_no_bubble", {63'd0, rd_valid}, 64'd1);
            if (prev_hold) begin
                chk("rd_hold_valid", {63'd0, rd_valid}, 64'd1);
                chk("rd_hold_data", rd_data, held);
            end
            if (rd_valid && rd_ready && exp_q.size() > 0) begin
                chk("rd_data", rd_data, exp_q.pop_front());
                rd_log.push_back(rd_data);
                r_left--;
                first_pending = 0;
            end
            prev_pop  = rd_valid && rd_ready;
            prev_hold = rd_valid && !rd_ready;
            held      = rd_data;
            // Read snapshot precedes the same-cycle write: reads see old data.
            if (rd_addr_valid && rd_addr_ready && rd_size != 0) begin
                for (int k = 0; k < int'(rd_size); k++)
                    exp_q.push_back(mem_m[(int'(rd_addr[ADDR_LSB +: 8]) + k) % 256]);
                r_left = int'(rd_size);
                first_pending = 1;
                first_cyc = cyc + 2;
            end
            if (wr_valid && wr_ready) begin
                if (w_left == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    mem_m[w_idx % 256] = wr_data;
                    w_idx++;
                    w_left--;
                end
            end
            if (wr_addr_valid && wr_addr_ready) begin
                w_idx  = int'(wr_addr[ADDR_LSB +: 8]);
                w_left = int'(wr_size);
            end
            rst_prev = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [31:0] addr, input int sz, input logic [63:0] base,
                            input bit incr, input int abort_at);
        int t;
        @(posedge clk); #1;
        wr_addr = addr; wr_size = BURST_W'(sz); wr_addr_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!wr_addr_ready && t < 50) begin t++; @(negedge clk); end
        if (t >= 50) chk("wr_addr_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        wr_addr_valid = 1'b0;
        for (int k = 0; k < sz; k++) begin
            wr_data  = incr ? base + 64'(k) : base;
            wr_valid = 1'b1;
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; wr_valid = 1'b0;
                return;
            end
            t = 0;
            @(negedge clk);
            while (!wr_ready && t < 50) begin t++; @(negedge clk); end
            if (t >= 50) begin chk("wr_beat_timeout", 64'd1, 64'd0); break; end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_done(input bit toggle);
        int c;
        c = 0;
        while (r_left != 0 && c < 400) begin
            @(posedge clk); #1;
            c++;
            rd_ready = toggle ? (c % 3 == 0) : 1'b1;
        end
        if (c >= 400) chk("rd_timeout", 64'd1, 64'd0);
        rd_ready = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int sz, input bit toggle);
        int t;
        rd_log.delete();
        @(posedge clk); #1;
        rd_addr = addr; rd_size = BURST_W'(sz); rd_addr_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rd_addr_ready && t < 50) begin t++; @(negedge clk); end
        if (t >= 50) chk("rd_addr_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        rd_addr_valid = 1'b0;
        wait_rd_done(toggle);
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [63:0] pat;
        pat = 64'hFFFF_FFFF_0000_0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: 32-beat write / read of a constant pattern, index 0 via high address bits
        do_write(32'h0400 << ADDR_LSB, 32, pat, 1'b0, -1);
        do_read(32'h0400 << ADDR_LSB, 32, 1'b0);
        chk("t1_count", 64'(rd_log.size()), 64'd32);
        for (int k = 0; k < rd_log.size(); k++) chk("t1_beat", rd_log[k], pat);

        // 3: wrap at top of RAM
        do_write(32'd250 << ADDR_LSB, 8, 64'd0, 1'b1, -1);
        do_read(32'd250 << ADDR_LSB, 8, 1'b0);
        chk("t3_count", 64'(rd_log.size()), 64'd8);
        for (int k = 0; k < rd_log.size(); k++) chk("t3_beat", rd_log[k], 64'(k));

        // 2: backpressure on the same burst
        do_read(32'd250 << ADDR_LSB, 8, 1'b1);
        chk("t2_count", 64'(rd_log.size()), 64'd8);
        for (int k = 0; k < rd_log.size(); k++) chk("t2_beat", rd_log[k], 64'(k));

        // 5: same-cycle write and read of index 3
        do_write(32'd3 << ADDR_LSB, 1, 64'd0, 1'b0, -1);
        @(posedge clk); #1;
        wr_addr = 32'd3 << ADDR_LSB; wr_size = 8'd1; wr_addr_valid = 1'b1;
        @(negedge clk);
        chk("t5_waddr_ready", {63'd0, wr_addr_ready}, 64'd1);
        @(posedge clk); #1;
        wr_addr_valid = 1'b0; wr_valid = 1'b1; wr_data = '1;
        rd_addr = 32'd3 << ADDR_LSB; rd_size = 8'd1; rd_addr_valid = 1'b1;
        rd_log.delete();
        @(negedge clk);
        chk("t5_same_cycle", {62'd0, wr_ready, rd_addr_ready}, 64'd3);
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_addr_valid = 1'b0;
        wait_rd_done(1'b0);
        chk("t5_count", 64'(rd_log.size()), 64'd1);
        if (rd_log.size() > 0) chk("t5_old", rd_log[0], 64'd0);
        do_read(32'd3 << ADDR_LSB, 1, 1'b0);
        chk("t5_count2", 64'(rd_log.size()), 64'd1);
        if (rd_log.size() > 0) chk("t5_new", rd_log[0], 64'hFFFF_FFFF_FFFF_FFFF);

        // 4: reset during beat 5 of a 32-beat write
        do_write(32'd100 << ADDR_LSB, 8, 64'h55, 1'b1, -1);
        do_write(32'd100 << ADDR_LSB, 32, 64'hA0, 1'b1, 5);
        do_read(32'd0, 4, 1'b0);
        chk("t4_rd0_count", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            chk("t4_rd0_b0", rd_log[0], 64'd6);
            chk("t4_rd0_b1", rd_log[1], 64'd7);
            chk("t4_rd0_b2", rd_log[2], pat);
            chk("t4_rd0_b3", rd_log[3], 64'hFFFF_FFFF_FFFF_FFFF);
        end
        do_read(32'd100 << ADDR_LSB, 8, 1'b0);
        chk("t4_count", 64'(rd_log.size()), 64'd8);
        for (int k = 0; k < rd_log.size(); k++)
            chk("t4_partial", rd_log[k], (k < 5) ? 64'hA0 + 64'(k) : 64'h55 + 64'(k));

        // 6: zero-size requests on both channels
        rd_log.delete();
        @(posedge clk); #1;
        rd_addr = '0; rd_size = '0; rd_addr_valid = 1'b1;
        wr_addr = '0; wr_size = '0; wr_addr_valid = 1'b1;
        @(negedge clk);
        chk("t6_both_ready", {62'd0, rd_addr_ready, wr_addr_ready}, 64'd3);
        @(posedge clk); #1;
        rd_addr_valid = 1'b0; wr_addr_valid = 1'b0;
        @(negedge clk);
        chk("t6_ready_next", {62'd0, rd_addr_ready, wr_addr_ready}, 64'd3);
        repeat (4) @(posedge clk);
        #1 chk("t6_no_beats", 64'(rd_log.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
